// File: rtl/rand_share_arb.sv
// rand_share_arb
// Shares one 16-bit xorshift generator among NREQ requesters. After reset or
// reseed the generator is stepped WARMUP times with the results discarded.
// After that, every grant consumes exactly one fresh generator step.
// Requesters are served round-robin. Grant, number and ack are registered.
module rand_share_arb #(
    parameter int          NREQ         = 4,
    parameter logic [15:0] SEED_DEFAULT = 16'h0004,
    parameter int          WARMUP       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_load,
    input  logic [15:0]     seed,
    output logic            seed_ack,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd,
    output logic            rnd_valid,
    output logic            busy
);

    localparam int         PTR_W     = $clog2(NREQ);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic {
        WARM,
        READY
    } state_t;

    state_t            state, state_next;
    logic [15:0]       x, x_next;
    logic [7:0]        cnt, cnt_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [NREQ-1:0]   gnt_next;
    logic [15:0]       rnd_next;
    logic              seed_ack_next;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PTR_W-1:0]  winner;

    // One xorshift step. Every shift is truncated to 16 bits.
    function automatic logic [15:0] nxt(input logic [15:0] s);
        logic [15:0] t;
        t = s ^ (s << 3);
        t = t ^ (t >> 11);
        t = t ^ (t << 7);
        return t;
    endfunction

    // Zero would lock the generator, so zero is mapped to one on every load.
    function automatic logic [15:0] fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // A requester that is seeing its grant right now cannot win again this cycle.
    assign eligible = req & ~gnt;

    // Round-robin search: first eligible index at or above ptr, otherwise the first from 0.
    always_comb begin
        // NOTE: give every combinational output a default first so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eligible[i] && (PTR_W'(i) >= ptr)) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = PTR_W'(i);
            end
        end
    end

    // State register together with the generator, counter, pointer and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments so every register samples the values from before the edge.
        if (rst) begin
            state    <= WARM;
            x        <= fix(SEED_DEFAULT);
            cnt      <= '0;
            ptr      <= '0;
            gnt      <= '0;
            rnd      <= '0;
            seed_ack <= 1'b0;
        end else begin
            state    <= state_next;
            x        <= x_next;
            cnt      <= cnt_next;
            ptr      <= ptr_next;
            gnt      <= gnt_next;
            rnd      <= rnd_next;
            seed_ack <= seed_ack_next;
        end
    end

    // Next state: a reseed beats everything, warm-up steps run freely, and grants are issued in READY.
    always_comb begin
        state_next    = state;
        x_next        = x;
        cnt_next      = cnt;
        ptr_next      = ptr;
        gnt_next      = '0;
        rnd_next      = rnd;
        seed_ack_next = 1'b0;

        if (seed_load) begin
            // A reseed in either state restarts warm-up. Pending requests stay pending.
            state_next    = WARM;
            x_next        = fix(seed);
            cnt_next      = '0;
            seed_ack_next = 1'b1;
        end else if (state == WARM) begin
            x_next = nxt(x);
            if (cnt == WARM_LAST) begin
                state_next = READY;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 8'd1;
            end
        end else if (found) begin
            gnt_next = NREQ'(1) << winner;
            rnd_next = nxt(x);
            x_next   = nxt(x);
            ptr_next = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Outputs derived directly from the state and the grant register.
    always_comb begin
        busy      = (state == WARM);
        rnd_valid = |gnt;
    end

endmodule
